output_classifier: RTL and testbench
====================================

OUTPUT_CLASSIFIER -- requirements
Module: output_classifier

Interface
REQ-001 SHALL have parameter DATA_W, default 10, signed data/weight width.
REQ-002 SHALL have parameter N_IN, default 5, hidden-layer values consumed.
REQ-003 SHALL have parameter N_OUT, default 3, output neurons/classes.
REQ-004 SHALL have parameter FRAC, default 5, fractional bits of data and weights.
REQ-005 SHALL have port Clock, input, 1, sole clock, rising edge.
REQ-006 SHALL have port Rst, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port wt_we, input, 1, weight write strobe.
REQ-008 SHALL have port wt_addr, input, 5, weight index = j*N_IN+i.
REQ-009 SHALL have port wt_data, input, DATA_W, signed weight.
REQ-010 SHALL have port in_valid, input, 1, hidden vector valid.
REQ-011 SHALL have port in_ready, output, 1, block can accept a vector.
REQ-012 SHALL have port in_val, input, N_IN x DATA_W, signed hidden-layer outputs.
REQ-013 SHALL have port out_valid, output, 1, result valid.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-015 SHALL have port out_val, output, N_OUT x DATA_W, signed neuron outputs.
REQ-016 SHALL have port out_class, output, 2, index of largest out_val.

Function
REQ-017 SHALL implement states IDLE, MAC, FINAL, HOLD; in_ready=1 only in IDLE.
REQ-018 SHALL capture in_val and go IDLE->MAC on the cycle in_valid&&in_ready.
REQ-019 SHALL in MAC perform one signed DATA_W x DATA_W multiply per cycle, j outer, i inner, N_IN*N_OUT cycles total (15 default).
REQ-020 SHALL accumulate each neuron in a 24-bit signed accumulator cleared at i=0.
REQ-021 SHALL at each neuron end arithmetic-shift the sum right by FRAC and saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] into out_val[j].
REQ-022 SHALL in FINAL (1 cycle) compute out_class as argmax of out_val, lowest index on ties, then enter HOLD.
REQ-023 SHALL assert out_valid in HOLD, exactly 16 cycles after the accept edge (default parameters).
REQ-024 SHALL keep out_val/out_class stable while out_valid && !out_ready; HOLD->IDLE on out_valid&&out_ready.
REQ-025 SHALL write weight[wt_addr]=wt_data on wt_we only in IDLE; writes in other states or to wt_addr >= N_IN*N_OUT (no bias) are ignored.
REQ-026 SHALL give priority to the vector accept over nothing: a simultaneous wt_we and accept in IDLE both take effect, the write visible to the next vector only.

Reset
REQ-027 SHALL on Rst=0 immediately force state IDLE, in_ready=1 after release, out_valid=0, out_val all 0, out_class=0, accumulator 0, all weights 0.
REQ-028 SHALL abort any MAC/HOLD in progress on reset with no output produced.

Configuration
REQ-029 SHALL, with OUTPUT_CLASSIFIER_BIAS_EN defined, add N_OUT signed bias registers at wt_addr 15..17, each added as (bias<<FRAC) to the accumulator before shift/saturate, reset to 0.
REQ-030 SHALL, without OUTPUT_CLASSIFIER_BIAS_EN, have no bias registers and ignore writes to addr 15..17.

Verification
REQ-031 SHALL pass: all weights 32, in_val all 32 -> out_val {160,160,160}, out_class 0, out_valid 16 cycles after accept.
REQ-032 SHALL pass: weights j=2 set to 64, others 32, in_val 32 -> out_val {160,160,320}, out_class 2.
REQ-033 SHALL pass: weights 511, in_val 511 -> out_val 511 all; weights -512, in_val 511 -> out_val -512 all.
REQ-034 SHALL pass: out_ready low 10 cycles in HOLD -> outputs stable, in_ready 0; wt_we during MAC -> weights unchanged on next vector.
REQ-035 SHALL pass: Rst low at MAC cycle 7 -> out_valid 0, all outputs 0, new vector after release yields REQ-031 values only after reloading weights.

Source files
------------

// File: rtl/output_classifier.sv
// Output layer: serial signed MAC over N_IN x N_OUT weights, saturating requantise, argmax class.
// Define OUTPUT_CLASSIFIER_BIAS_EN to add per-neuron bias registers at wt_addr N_IN*N_OUT upward.
module output_classifier #(
  parameter int DATA_W = 10,
  parameter int N_IN   = 5,
  parameter int N_OUT  = 3,
  parameter int FRAC   = 5
) (
  input  logic                      Clock,
  input  logic                      Rst,
  input  logic                      wt_we,
  input  logic [4:0]                wt_addr,
  input  logic [DATA_W-1:0]         wt_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*DATA_W-1:0]    in_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*DATA_W-1:0]   out_val,
  output logic [1:0]                out_class
);
  localparam int ACC_W  = 24;
  localparam int NW     = N_IN * N_OUT;
  localparam int I_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int J_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int W_W    = (NW > 1) ? $clog2(NW) : 1;
  localparam int SAT_HI = 2**(DATA_W-1) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_HI);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_HI - 1);

  typedef enum logic [1:0] {IDLE, MAC, FINAL, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [I_W-1:0]           i_q, i_d;
  logic [J_W-1:0]           j_q, j_d;
  logic [W_W-1:0]           widx_q, widx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] in_q  [N_IN];
  logic signed [DATA_W-1:0] in_d  [N_IN];
  logic signed [DATA_W-1:0] wt_q  [NW];
  logic signed [DATA_W-1:0] wt_d  [NW];
  logic signed [DATA_W-1:0] res_q [N_OUT];
  logic signed [DATA_W-1:0] res_d [N_OUT];
  logic [1:0]               class_q, class_d;
  logic                     pend_q, pend_d;
  logic [4:0]               pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]        pend_data_q, pend_data_d;
`ifdef OUTPUT_CLASSIFIER_BIAS_EN
  logic signed [DATA_W-1:0] bias_q [N_OUT];
  logic signed [DATA_W-1:0] bias_d [N_OUT];
`endif

  logic                       accept;
  logic                       wr_en;
  logic [4:0]                 wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    bias_term;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [DATA_W-1:0]   sat;
  logic signed [DATA_W-1:0]   best_val;
  logic [1:0]                 best_idx;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign out_class = class_q;

  always_comb begin
    prod     = (2*DATA_W)'(in_q[i_q]) * (2*DATA_W)'(wt_q[widx_q]);
    acc_next = ((i_q == '0) ? '0 : acc_q) + ACC_W'(prod);
    bias_term = '0;
`ifdef OUTPUT_CLASSIFIER_BIAS_EN
    bias_term = ACC_W'(bias_q[j_q]) <<< FRAC;
`endif
    shifted = (acc_next + bias_term) >>> FRAC;
    if (shifted > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                        sat = shifted[DATA_W-1:0];
  end

  always_comb begin
    best_val = res_q[0];
    best_idx = '0;
    for (int unsigned k = 1; k < N_OUT; k++) begin
      if (res_q[k] > best_val) begin
        best_val = res_q[k];
        best_idx = 2'(k);
      end
    end
  end

  always_comb begin
    out_val = '0;
    for (int unsigned k = 0; k < N_OUT; k++) out_val[k*DATA_W +: DATA_W] = res_q[k];
  end

  // A write arriving on the accept cycle is parked and committed on HOLD exit,
  // so the vector just captured still sees the old weight set.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    widx_d      = widx_q;
    acc_d       = acc_q;
    in_d        = in_q;
    res_d       = res_q;
    class_d     = class_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wr_en       = 1'b0;
    wr_addr     = wt_addr;
    wr_data     = wt_data;
    unique case (state_q)
      IDLE: begin
        wr_en = wt_we && !accept;
        if (accept) begin
          for (int unsigned k = 0; k < N_IN; k++) in_d[k] = in_val[k*DATA_W +: DATA_W];
          i_d         = '0;
          j_d         = '0;
          widx_d      = '0;
          pend_d      = wt_we;
          pend_addr_d = wt_addr;
          pend_data_d = wt_data;
          state_d     = MAC;
        end
      end
      MAC: begin
        acc_d  = acc_next;
        widx_d = widx_q + W_W'(1);
        if (i_q == I_W'(N_IN-1)) begin
          i_d        = '0;
          res_d[j_q] = sat;
          if (j_q == J_W'(N_OUT-1)) state_d = FINAL;
          else                      j_d = j_q + J_W'(1);
        end else begin
          i_d = i_q + I_W'(1);
        end
      end
      FINAL: begin
        class_d = best_idx;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          if (pend_q) begin
            wr_en   = 1'b1;
            wr_addr = pend_addr_q;
            wr_data = pend_data_q;
            pend_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wt_d = wt_q;
    for (int unsigned k = 0; k < NW; k++)
      if (wr_en && wr_addr == 5'(k)) wt_d[k] = wr_data;
`ifdef OUTPUT_CLASSIFIER_BIAS_EN
    bias_d = bias_q;
    for (int unsigned k = 0; k < N_OUT; k++)
      if (wr_en && wr_addr == 5'(NW + k)) bias_d[k] = wr_data;
`endif
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      widx_q      <= '0;
      acc_q       <= '0;
      in_q        <= '{default: '0};
      wt_q        <= '{default: '0};
      res_q       <= '{default: '0};
      class_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
`ifdef OUTPUT_CLASSIFIER_BIAS_EN
      bias_q      <= '{default: '0};
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      widx_q      <= widx_d;
      acc_q       <= acc_d;
      in_q        <= in_d;
      wt_q        <= wt_d;
      res_q       <= res_d;
      class_q     <= class_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
`ifdef OUTPUT_CLASSIFIER_BIAS_EN
      bias_q      <= bias_d;
`endif
    end
  end
endmodule

// File: tb/tb_output_classifier.sv
// Bench for output_classifier: fixed vector table, directed corner sequences, random vs reference model.
module tb_output_classifier;
  localparam int DW = 10;
  localparam int NI = 5;
  localparam int NO = 3;
  localparam int FR = 5;
  localparam int NW = NI * NO;

  logic              Clock = 1'b0;
  logic              Rst = 1'b0;
  logic              wt_we = 1'b0;
  logic [4:0]        wt_addr = '0;
  logic [DW-1:0]     wt_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NI*DW-1:0]  in_val = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NO*DW-1:0]  out_val;
  logic [1:0]        out_class;

  int tests = 0;
  int fails = 0;
  int w_m[NW];
  int b_m[NO];

  typedef struct {
    int w0; int w1; int w2; int x;
    int e0; int e1; int e2; int ec;
  } vec_t;

  always #5 Clock = ~Clock;

  output_classifier #(.DATA_W(DW), .N_IN(NI), .N_OUT(NO), .FRAC(FR)) dut (
    .Clock(Clock), .Rst(Rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_class(out_class)
  );

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: dot product per class, floor-divide by 2^FR, clamp, first maximum wins.
  task automatic model(input int x[NI], output int ov[NO], output int cls);
    int s;
    int lim;
    lim = 1 << (DW - 1);
    for (int j = 0; j < NO; j++) begin
      s = 0;
      for (int i = 0; i < NI; i++) s += w_m[j*NI + i] * x[i];
`ifdef OUTPUT_CLASSIFIER_BIAS_EN
      s += b_m[j] * (1 << FR);
`endif
      s = s >>> FR;
      if (s > lim - 1) s = lim - 1;
      if (s < -lim) s = -lim;
      ov[j] = s;
    end
    cls = 0;
    for (int j = 1; j < NO; j++) if (ov[j] > ov[cls]) cls = j;
  endtask

  task automatic write_w(input int addr, input int data);
    @(negedge Clock);
    wt_we = 1'b1;
    wt_addr = 5'(addr);
    wt_data = DW'(data);
    @(negedge Clock);
    wt_we = 1'b0;
    if (addr < NW) w_m[addr] = data;
`ifdef OUTPUT_CLASSIFIER_BIAS_EN
    else if (addr < NW + NO) b_m[addr - NW] = data;
`endif
  endtask

  task automatic load_all(input int v0, input int v1, input int v2);
    for (int j = 0; j < NO; j++)
      for (int i = 0; i < NI; i++)
        write_w(j*NI + i, (j == 0) ? v0 : (j == 1) ? v1 : v2);
  endtask

  task automatic read_out(output int ov[NO]);
    for (int j = 0; j < NO; j++) ov[j] = int'($signed(out_val[j*DW +: DW]));
  endtask

  task automatic do_vector(input int x[NI], input int stall, input bit sim_we, input int sim_addr,
                           input int sim_data, input bit mac_we,
                           output int ov[NO], output int cls, output int lat);
    int snap_v;
    int snap_c;
    @(negedge Clock);
    for (int i = 0; i < NI; i++) in_val[i*DW +: DW] = DW'(x[i]);
    in_valid = 1'b1;
    out_ready = 1'b0;
    if (sim_we) begin
      wt_we = 1'b1;
      wt_addr = 5'(sim_addr);
      wt_data = DW'(sim_data);
    end
    check("accept_ready", int'(in_ready), 1);
    @(posedge Clock); #1;
    in_valid = 1'b0;
    wt_we = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (mac_we && lat == 3) begin
        wt_we = 1'b1;
        wt_addr = 5'd0;
        wt_data = DW'(100);
      end
      @(posedge Clock); #1;
      wt_we = 1'b0;
      lat++;
    end
    read_out(ov);
    cls = int'(out_class);
    snap_v = int'(out_val);
    snap_c = cls;
    for (int s = 0; s < stall; s++) begin
      @(posedge Clock); #1;
      check("stall_val", int'(out_val), snap_v);
      check("stall_class", int'(out_class), snap_c);
      check("stall_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge Clock); #1;
    out_ready = 1'b0;
    check("back_idle", int'(in_ready), 1);
  endtask

  task automatic run_model(input string name, input int x[NI], input int stall,
                           input bit sim_we, input int sim_addr, input int sim_data, input bit mac_we);
    int ov[NO];
    int eov[NO];
    int cls;
    int ecls;
    int lat;
    model(x, eov, ecls);
    do_vector(x, stall, sim_we, sim_addr, sim_data, mac_we, ov, cls, lat);
    check({name, "_lat"}, lat, 16);
    for (int j = 0; j < NO; j++) check($sformatf("%s_ov%0d", name, j), ov[j], eov[j]);
    check({name, "_class"}, cls, ecls);
  endtask

  initial begin
    vec_t tbl[8];
    int x[NI];
    int ov[NO];
    int cls;
    int lat;
    tbl[0] = '{32, 32, 32, 32, 160, 160, 160, 0};
    tbl[1] = '{32, 32, 64, 32, 160, 160, 320, 2};
    tbl[2] = '{511, 511, 511, 511, 511, 511, 511, 0};
    tbl[3] = '{-512, -512, -512, 511, -512, -512, -512, 0};
    tbl[4] = '{0, -32, 32, 32, 0, -160, 160, 2};
    tbl[5] = '{-32, -64, -32, -32, 160, 320, 160, 1};
    tbl[6] = '{16, 32, 32, 32, 80, 160, 160, 1};
    tbl[7] = '{1, -1, 0, 1, 0, -1, 0, 0};
    for (int k = 0; k < NW; k++) w_m[k] = 0;
    for (int k = 0; k < NO; k++) b_m[k] = 0;

    repeat (3) @(negedge Clock);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_val", int'(out_val), 0);
    check("rst_out_class", int'(out_class), 0);
    Rst = 1'b1;
    @(posedge Clock); #1;
    check("rst_in_ready", int'(in_ready), 1);

    for (int t = 0; t < 8; t++) begin
      load_all(tbl[t].w0, tbl[t].w1, tbl[t].w2);
      for (int i = 0; i < NI; i++) x[i] = tbl[t].x;
      do_vector(x, 0, 1'b0, 0, 0, 1'b0, ov, cls, lat);
      check($sformatf("tbl%0d_lat", t), lat, 16);
      check($sformatf("tbl%0d_ov0", t), ov[0], tbl[t].e0);
      check($sformatf("tbl%0d_ov1", t), ov[1], tbl[t].e1);
      check($sformatf("tbl%0d_ov2", t), ov[2], tbl[t].e2);
      check($sformatf("tbl%0d_class", t), cls, tbl[t].ec);
    end

    load_all(32, 32, 32);
    for (int i = 0; i < NI; i++) x[i] = 32;
    run_model("stall10", x, 10, 1'b0, 0, 0, 1'b0);
    run_model("mac_write", x, 0, 1'b0, 0, 0, 1'b1);
    run_model("after_mac_write", x, 0, 1'b0, 0, 0, 1'b0);
    run_model("accept_write", x, 0, 1'b1, 0, 64, 1'b0);
    w_m[0] = 64;
    run_model("after_accept_write", x, 1, 1'b0, 0, 0, 1'b0);

    write_w(15, 100);
    write_w(16, 100);
    write_w(17, 100);
    write_w(31, 100);
    for (int i = 0; i < NI; i++) x[i] = 32;
    run_model("high_addr", x, 0, 1'b0, 0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < NW; k++) write_w(k, int'($urandom_range(0, 1023)) - 512);
      for (int i = 0; i < NI; i++) x[i] = int'($urandom_range(0, 1023)) - 512;
      run_model($sformatf("rand%0d", r), x, int'($urandom_range(0, 2)), 1'b0, 0, 0, 1'b0);
    end

    // Reset in the middle of MAC
    load_all(32, 32, 32);
    for (int i = 0; i < NI; i++) x[i] = 32;
    run_model("pre_reset", x, 0, 1'b0, 0, 0, 1'b0);
    @(negedge Clock);
    in_valid = 1'b1;
    @(posedge Clock); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge Clock);
    #2 Rst = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_val", int'(out_val), 0);
    check("mid_rst_out_class", int'(out_class), 0);
    for (int k = 0; k < NW; k++) w_m[k] = 0;
    for (int k = 0; k < NO; k++) b_m[k] = 0;
    @(negedge Clock);
    Rst = 1'b1;
    @(posedge Clock); #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);
    do_vector(x, 0, 1'b0, 0, 0, 1'b0, ov, cls, lat);
    check("cleared_w_ov0", ov[0], 0);
    check("cleared_w_ov1", ov[1], 0);
    check("cleared_w_ov2", ov[2], 0);
    check("cleared_w_class", cls, 0);
    load_all(32, 32, 32);
    do_vector(x, 0, 1'b0, 0, 0, 1'b0, ov, cls, lat);
    check("reload_lat", lat, 16);
    check("reload_ov0", ov[0], 160);
    check("reload_ov1", ov[1], 160);
    check("reload_ov2", ov[2], 160);
    check("reload_class", cls, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
